// File: rtl/serial_max_sched_pkg.sv
// Shared definitions for the serial running-max scheduler: FSM encodings
// and the state type used by the debug port.
package serial_max_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/serial_max_core.sv
// Running signed maximum. clr reloads the most negative value; an enabled
// sample strictly greater than the current max replaces it. upd flags that
// replacement in the same cycle so the caller can capture the index.
module serial_max_core #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] in,
  output logic signed [WIDTH-1:0] max,
  output logic                    upd
);

  localparam logic signed [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] max_q;

  // Strict compare: ties keep the earlier maximum.
  assign upd = en && ($signed(in) > $signed(max_q));
  assign max = max_q;

  // Max register: clear on frame start, load on a strictly larger sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_q <= MIN;
    end else if (clr) begin
      max_q <= MIN;
    end else if (upd) begin
      max_q <= in;
    end
  end

endmodule

// File: rtl/serial_max_sched.sv
// Frame scheduler around serial_max_core. A start in IDLE with a legal
// length opens a frame; exactly len samples are pulled, then {max, arg} is
// held until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high exactly in RUN, out_valid exactly in DONE;
// both decode from the registered state, so neither depends combinationally
// on the opposite side's valid/ready. Once out_valid rises, max and arg hold
// until the edge that sees out_ready high.
module serial_max_sched
  import serial_max_sched_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    err,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] max,
  output logic [IDX_W-1:0]        arg,
  output logic [1:0]              dbg_state
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] arg_q;
  logic             err_q;

  logic is_idle, is_run, is_done;
  logic len_ok, start_ok, beat, last_beat, upd;

  assign is_idle = (state_q == S_IDLE);
  assign is_run  = (state_q == S_RUN);
  assign is_done = (state_q == S_DONE);

  assign len_ok    = (len != '0) && (len <= MAX_LEN_L);
  assign start_ok  = is_idle && start && len_ok;
  assign beat      = is_run && in_valid;
  assign last_beat = beat && (LEN_W'(idx_q) == (len_q - LEN_W'(1)));

  assign in_ready  = is_run;
  assign out_valid = is_done;
  assign busy      = is_run || is_done;
  assign err       = err_q;
  assign arg       = arg_q;
  assign dbg_state = state_q;

  serial_max_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (beat),
    .in  (in),
    .max (max),
    .upd (upd)
  );

  // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (last_beat) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame length and sample index; idx stops at len_q-1 so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
      idx_q <= '0;
    end else if (start_ok) begin
      len_q <= len;
      idx_q <= '0;
    end else if (beat && !last_beat) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Index of the first occurrence of the maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arg_q <= '0;
    end else if (start_ok) begin
      arg_q <= '0;
    end else if (upd) begin
      arg_q <= idx_q;
    end
  end

  // One-cycle error pulse for a start with an illegal length in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= is_idle && start && !len_ok;
    end
  end

endmodule
